// File: rtl/rsc_viterbi_pkg.sv
// Shared types, constants and trellis equations for the 8-state RSC Viterbi decoder
// (g0 = 1+D^2+D^3 feedback, g1 = 1+D+D^3 parity); state bit [2] is s0, the newest.
package rsc_viterbi_pkg;

  localparam int NSTATES = 8;
  localparam int TAIL    = 3;
  localparam int PM_INIT = 128;

  typedef enum logic [1:0] {
    IDLE,
    ACS,
    TB,
    DONE
  } fsm_t;

  // Expected systematic bit when leaving `state` with feedback bit a.
  function automatic logic exp_sys(input logic [2:0] state, input logic a);
    return a ^ state[1] ^ state[0];
  endfunction

  function automatic logic exp_par(input logic [2:0] state, input logic a);
    return a ^ state[2] ^ state[0];
  endfunction

  // Predecessor of next state {n2,n1,n0} is {n1,n0,b}; the feedback bit of that edge is n2.
  function automatic logic [2:0] pred(input logic [2:0] nxt, input logic b);
    return {nxt[1:0], b};
  endfunction

endpackage

// File: rtl/rsc_acs_unit.sv
// Combinational add-compare-select for one next state: saturating metrics,
// ties resolved toward the b=0 predecessor, feedback-1 states blocked during tail.
module rsc_acs_unit
  import rsc_viterbi_pkg::*;
#(
  parameter int PMW = 8
) (
  input  logic [PMW-1:0] pm_b0,
  input  logic [PMW-1:0] pm_b1,
  input  logic           sys_bit,
  input  logic           par_bit,
  input  logic [2:0]     nxt,
  input  logic           tail,
  output logic [PMW-1:0] pm_new,
  output logic           dec
);

  localparam logic [PMW-1:0] PM_MAX = '1;

  function automatic logic [PMW-1:0] sat_add(input logic [PMW-1:0] pm, input logic [1:0] bm);
    logic [PMW:0] s;
    s = {1'b0, pm} + {{(PMW-1){1'b0}}, bm};
    return s[PMW] ? PM_MAX : s[PMW-1:0];
  endfunction

  logic [2:0]     p0;
  logic [2:0]     p1;
  logic [1:0]     bm0;
  logic [1:0]     bm1;
  logic [PMW-1:0] cand0;
  logic [PMW-1:0] cand1;

  assign p0    = pred(nxt, 1'b0);
  assign p1    = pred(nxt, 1'b1);
  assign bm0   = {1'b0, exp_sys(p0, nxt[2]) ^ sys_bit} + {1'b0, exp_par(p0, nxt[2]) ^ par_bit};
  assign bm1   = {1'b0, exp_sys(p1, nxt[2]) ^ sys_bit} + {1'b0, exp_par(p1, nxt[2]) ^ par_bit};
  assign cand0 = sat_add(pm_b0, bm0);
  assign cand1 = sat_add(pm_b1, bm1);

  always_comb begin
    pm_new = cand0;
    dec    = 1'b0;
    if (tail && nxt[2]) begin
      pm_new = PM_MAX;
    end else if (cand1 < cand0) begin
      pm_new = cand1;
      dec    = 1'b1;
    end
  end

endmodule

// File: rtl/rsc_viterbi_decoder.sv
// Hard-decision Viterbi decoder for one NB-IoT turbo constituent code: one ACS step per
// valid symbol pair, then a T-cycle traceback from state 0 into the parallel dout register.
module rsc_viterbi_decoder
  import rsc_viterbi_pkg::*;
#(
  parameter int K   = 40,
  parameter int PMW = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           in_valid,
  input  logic           sys_bit,
  input  logic           par_bit,
  output logic           busy,
  output logic           done,
  output logic [0:K-1]   dout,
  output logic [PMW-1:0] err_metric
);

  localparam int T  = K + TAIL;
  localparam int TW = $clog2(T);
  localparam logic [TW-1:0] T_LAST = TW'(T - 1);
  localparam logic [TW-1:0] K_W    = TW'(K);

  fsm_t               state_q, state_d;
  logic [TW-1:0]      t_q, t_d;
  logic [PMW-1:0]     pm_q [NSTATES];
  logic [PMW-1:0]     pm_d [NSTATES];
  logic [NSTATES-1:0] surv_q [T];
  logic [NSTATES-1:0] surv_d [T];
  logic [2:0]         tb_state_q, tb_state_d;
  logic [0:K-1]       dout_q, dout_d;
  logic [PMW-1:0]     err_metric_q, err_metric_d;

  logic [PMW-1:0]     pm_new [NSTATES];
  logic [NSTATES-1:0] dec;
  logic               tail;
  logic               tb_b;

  assign tail = (t_q >= K_W);

  for (genvar n = 0; n < NSTATES; n++) begin : g_acs
    localparam logic [2:0] NXT = 3'(n);
    rsc_acs_unit #(.PMW(PMW)) u_acs (
      .pm_b0   (pm_q[pred(NXT, 1'b0)]),
      .pm_b1   (pm_q[pred(NXT, 1'b1)]),
      .sys_bit (sys_bit),
      .par_bit (par_bit),
      .nxt     (NXT),
      .tail    (tail),
      .pm_new  (pm_new[n]),
      .dec     (dec[n])
    );
  end

  always_comb begin
    state_d      = state_q;
    t_d          = t_q;
    pm_d         = pm_q;
    surv_d       = surv_q;
    tb_state_d   = tb_state_q;
    dout_d       = dout_q;
    err_metric_d = err_metric_q;
    tb_b         = surv_q[t_q][tb_state_q];

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACS;
          t_d     = '0;
          for (int i = 0; i < NSTATES; i++) pm_d[i] = PMW'(PM_INIT);
          pm_d[0] = '0;
        end
      end
      ACS: begin
        if (in_valid) begin
          pm_d        = pm_new;
          surv_d[t_q] = dec;
          if (t_q == T_LAST) begin
            state_d    = TB;
            tb_state_d = '0;
          end else begin
            t_d = t_q + TW'(1);
          end
        end
      end
      TB: begin
        // Tail steps are walked to reach the information section but produce no output.
        if (t_q < K_W) dout_d[t_q] = tb_state_q[2] ^ tb_state_q[0] ^ tb_b;
        tb_state_d = pred(tb_state_q, tb_b);
        if (t_q == '0) begin
          state_d      = DONE;
          err_metric_d = pm_q[0];
        end else begin
          t_d = t_q - TW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      t_q          <= '0;
      tb_state_q   <= '0;
      dout_q       <= '0;
      err_metric_q <= '0;
      for (int i = 0; i < NSTATES; i++) pm_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      t_q          <= t_d;
      tb_state_q   <= tb_state_d;
      dout_q       <= dout_d;
      err_metric_q <= err_metric_d;
      pm_q         <= pm_d;
    end
  end

  always_ff @(posedge clk) begin
    surv_q <= surv_d;
  end

  assign busy       = (state_q == ACS) || (state_q == TB);
  assign done       = (state_q == DONE);
  assign dout       = dout_q;
  assign err_metric = err_metric_q;

endmodule

// File: doc/rsc_viterbi_decoder.md
Name: rsc_viterbi_decoder

Overview:
Hard-decision Viterbi decoder for one 8-state constituent recursive systematic convolutional code of the NB-IoT uplink turbo encoder (g0 = 1+D^2+D^3, g1 = 1+D+D^3).
- Accepts K systematic/parity bit pairs plus 3 tail pairs. Runs add-compare-select per symbol, then traces back from state 0.
- Presents the K decoded bits in parallel together with the final path metric.
- Sits on the loopback/verification side of the turbo encoder chain, checking and recovering the constituent encoder output.

Parameters:
K, 40, information block length in bits (tail adds 3 trellis steps; T = K+3)
PMW, 8, path metric width in bits

Ports:
clk  input  1  clock
rst  input  1  reset (synchronous, active-high)
start  input  1  one-cycle pulse; begins a block (ignored unless IDLE)
in_valid  input  1  sys_bit/par_bit valid this cycle
sys_bit  input  1  received systematic bit (hard decision)
par_bit  input  1  received parity bit (hard decision)
busy  output  1  high from accepted start until done
done  output  1  one-cycle pulse; dout and err_metric valid
dout  output  [0:K-1]  decoded bits, dout[0] = first information bit
err_metric  output  PMW  final state-0 path metric (Hamming distance of best path)

Behaviour:
- Reset values: busy=0, done=0, dout=0, err_metric=0, FSM=IDLE, step counter=0. All 8 path metrics cleared.
- Trellis:
  - State index {s0,s1,s2}, s0 = MSB.
  - Input x gives feedback a = x^s1^s2 and parity z = a^s0^s2. Next state = {a,s0,s1}. Expected symbol pair = (x,z).
- Tail steps (t = K..K+2): only the a=0 branch is legal, so x = s1^s2 and z = s0^s2. The a=1 branch is excluded; states with MSB=1 get metric 2^PMW-1.
- Branch metric: Hamming distance between (sys_bit,par_bit) and expected (x,z), range 0..2.
- Predecessors of next state {n2,n1,n0} are {n1,n0,b}, b in {0,1}.
  - Candidate metric = PM[pred] + BM, saturating at 2^PMW-1.
  - Select the smaller candidate; on a tie select b=0.
  - Store decision bit b in survivor[t][next].
  - Decoded bit on that transition is x = n2^n0^b.
- Metric initialisation on start: PM[0]=0, PM[1..7]=128. Worst legal metric 2*T=86, so there is no overflow at defaults.
- FSM:
  - IDLE: start -> ACS, t=0, metrics initialised, busy=1 next cycle.
  - ACS: each cycle with in_valid=1 performs one trellis step (all 8 states in parallel), t++. Cycles with in_valid=0 hold state. After step t=T-1 -> TB.
  - TB: begins at state 0, t=T-1. Each cycle reads the decision bit, computes x, writes dout[t] when t<K, moves to the predecessor, t--. After t=0 -> DONE. Tail decisions are traversed but not output. Takes exactly T cycles.
  - DONE: one cycle; done=1, err_metric=PM[0] captured at end of ACS, busy=0 -> IDLE.
- Latency: done asserts T+1 cycles after the cycle accepting the last tail symbol.
- dout/err_metric hold until the next done or reset. dout bits update during TB, so they are valid only at done.
- start while busy: ignored. in_valid in IDLE/TB/DONE: ignored, no effect.
- start and in_valid in the same IDLE cycle: the symbol is not consumed; the first symbol is accepted the cycle after start.
- rst mid-block (any state): immediate return to IDLE with reset values. Partial survivor contents are don't-care.
- Survivor memory: T x 8 bits of flops, indexed by step.

Decomposition:
- Package rsc_viterbi_pkg:
  - NSTATES=8, TAIL=3, FSM state enum (IDLE, ACS, TB, DONE)
  - metric init constant 128
  - functions exp_sys(state,a) / exp_par(state,a) and pred(next,b) implementing the trellis equations above
- Sub-module rsc_acs_unit: one instance per next state. Takes two predecessor metrics, received pair, next-state index and tail flag. Returns new metric and decision bit. Purely combinational; the top holds all registers.

Test Plan:
- All-zero info, K=40, error-free (80 zeros + zero tail) -> dout=0, err_metric=0, done exactly 44 cycles after last tail symbol.
- Info 1,0,1,1,0... (alternating-pair pattern), error-free encoder output with correct tail -> dout equals info bits, err_metric=0.
- Same stream with par_bit flipped at t=10 and sys_bit flipped at t=30 -> dout equals info bits, err_metric=2.
- in_valid deasserted for 3 cycles at t=5 and t=20 -> result identical to the gap-free run, done delayed by 6 cycles.
- start pulsed again at t=15 -> ignored; decode completes normally, busy stays 1.
- rst asserted at t=25, then a fresh error-free block -> busy=0/done=0 the cycle after rst; second block decodes correctly, err_metric=0.
